// File: rtl/conc_trace_recorder_if.sv
// ----------------------------------------------------------------------------
// conc_trace_recorder_if
//
// Bundles the control, sample and read-port signals of conc_trace_recorder.
// The clock and reset stay outside as plain ports of the recorder.
//
//   master : the bench/checker side. It drives arm/stop/trig, the b12 output
//            sample (nloss, nl, speaker) and rd_en. It observes rd_valid,
//            rd_data, count, full, overflow and done.
//   slave  : the recorder side, with the opposite directions.
//
// Parameters must match those of the recorder instance:
//   DEPTH   number of trace records (power of two, >= 2)
//   STAMP_W width of the cycle stamp; a record is STAMP_W + 6 bits wide
// ----------------------------------------------------------------------------
interface conc_trace_recorder_if #(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 8
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = STAMP_W + 6;

    logic             arm;
    logic             stop;
    logic             trig;
    logic             nloss;
    logic [3:0]       nl;
    logic             speaker;
    logic             rd_en;
    logic             rd_valid;
    logic [REC_W-1:0] rd_data;
    logic [AW:0]      count;
    logic             full;
    logic             overflow;
    logic             done;

    modport master (
        output arm, stop, trig, nloss, nl, speaker, rd_en,
        input  rd_valid, rd_data, count, full, overflow, done
    );

    modport slave (
        input  arm, stop, trig, nloss, nl, speaker, rd_en,
        output rd_valid, rd_data, count, full, overflow, done
    );
endinterface

// File: rtl/conc_trace_recorder.sv
// ----------------------------------------------------------------------------
// conc_trace_recorder
//
// Samples the b12 outputs {speaker, nl[3:0], nloss} every clock edge once
// capture has started and stores them as time-stamped records
// {stamp, speaker, nl, nloss} in an internal trace buffer. The buffer is
// drained through a one-cycle-latency read port while the recorder is idle
// or done.
//
// Ports:
//   clock         sampling clock
//   reset         asynchronous, active-high reset
//   bus (slave)   arm     : pulse, clear buffer and wait for trigger
//                 stop    : pulse, end capture
//                 trig    : level, starts capture while armed
//                 nloss, nl, speaker : sampled DUT outputs
//                 rd_en   : read request (honoured in IDLE/DONE only)
//                 rd_valid, rd_data : registered read response
//                 count   : records held, full : count == DEPTH
//                 overflow: sticky, a capture cycle was dropped
//                 done    : capture finished
//
// Optional build macro CONC_TRACE_DEDUP_EN: when defined, capture writes a
// record only when the sample differs from the last written one (record 0
// is always written); the stamp still advances every capture cycle.
// ----------------------------------------------------------------------------
module conc_trace_recorder #(
    parameter int DEPTH   = 16,
    parameter int STAMP_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    conc_trace_recorder_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = STAMP_W + 6;

    localparam logic [AW-1:0]      PTR_ONE   = 1;
    localparam logic [AW:0]        CNT_ONE   = 1;
    localparam logic [AW:0]        CNT_FULL  = DEPTH[AW:0];
    localparam logic [STAMP_W-1:0] STAMP_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Saturating stamp increment: once all-ones the stamp stays there so a
    // long capture never produces a stamp that looks earlier than its
    // predecessor.
    function automatic logic [STAMP_W-1:0] sat_inc(input logic [STAMP_W-1:0] s);
        if (&s) begin
            return s;
        end
        return s + STAMP_ONE;
    endfunction

    state_t state, state_nxt;

    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [STAMP_W-1:0] stamp;
    logic               overflow;
    logic               done_r;
    logic               rd_vld_p1;
    logic [REC_W-1:0]   rd_data_p1;

    logic [5:0]         smp;
    logic               smp_new;
    logic               full;
    logic               wr_en;
    logic               rd_fire;
    logic               clr;
    logic               ovf_set;

    assign smp  = {bus.speaker, bus.nl, bus.nloss};
    assign full = (count == CNT_FULL);

`ifdef CONC_TRACE_DEDUP_EN
    logic [5:0] last_smp;

    assign smp_new = (smp != last_smp);

    always_ff @(posedge clock) begin
        if (wr_en) begin
            last_smp <= smp;
        end
    end
`else
    assign smp_new = 1'b1;
`endif

    // ---- control: next state and per-cycle actions -------------------------
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_fire   = 1'b0;
        clr       = 1'b0;
        ovf_set   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                // arm wins over a simultaneous read request
                if (bus.arm) begin
                    clr       = 1'b1;
                    state_nxt = S_ARMED;
                end else if (bus.rd_en && (count != '0)) begin
                    rd_fire = 1'b1;
                end
            end
            S_ARMED: begin
                if (bus.arm) begin
                    clr = 1'b1;
                end else if (bus.stop) begin
                    state_nxt = S_DONE;
                end else if (bus.trig) begin
                    // record 0 is written unconditionally on the trigger edge
                    wr_en     = 1'b1;
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (full) begin
                    // a sample that would have been recorded is lost
                    if (smp_new) begin
                        ovf_set   = 1'b1;
                        state_nxt = S_DONE;
                    end else if (bus.stop) begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    wr_en = smp_new;
                    if (bus.stop) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- control registers ---------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            stamp      <= '0;
            overflow   <= 1'b0;
            done_r     <= 1'b0;
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= '0;
        end else begin
            state     <= state_nxt;
            done_r    <= (state_nxt == S_DONE);
            rd_vld_p1 <= rd_fire;

            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                stamp    <= '0;
                overflow <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    count  <= count + CNT_ONE;
                end
                if (rd_fire) begin
                    rd_ptr     <= rd_ptr + PTR_ONE;
                    count      <= count - CNT_ONE;
                    rd_data_p1 <= mem[rd_ptr];
                end
                // stamp counts every capture edge, including the trigger edge
                if (wr_en || (state == S_CAPTURE)) begin
                    stamp <= sat_inc(stamp);
                end
                if (ovf_set) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // ---- trace storage (data path, not reset) -------------------------------
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= {stamp, smp};
        end
    end

    assign bus.rd_valid = rd_vld_p1;
    assign bus.rd_data  = rd_data_p1;
    assign bus.count    = count;
    assign bus.full     = full;
    assign bus.overflow = overflow;
    assign bus.done     = done_r;

endmodule

// File: tb/tb_conc_trace_recorder.sv
// ----------------------------------------------------------------------------
// tb_conc_trace_recorder
//
// Directed bench for conc_trace_recorder (DEPTH = 16, STAMP_W = 8). Inputs
// are driven one time unit after the rising edge and outputs are sampled at
// the same point, so every value seen reflects the preceding edge.
// ----------------------------------------------------------------------------
module tb_conc_trace_recorder;
    localparam int DEPTH   = 16;
    localparam int STAMP_W = 8;

    logic clock;
    logic reset;
    int   n_chk;
    int   n_fail;

    conc_trace_recorder_if #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) bus ();

    conc_trace_recorder #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic arm_pulse();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic set_smp(input int i);
        bus.nl      = 4'(i);
        bus.speaker = 1'b0;
        bus.nloss   = 1'b0;
    endtask

    // record layout {stamp, speaker, nl, nloss} with speaker = nloss = 0
    function automatic logic [31:0] rec(input int st, input int n);
        logic [13:0] r;
        r = {8'(st), 1'b0, 4'(n), 1'b0};
        return 32'(r);
    endfunction

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.arm     = 1'b0;
        bus.stop    = 1'b0;
        bus.trig    = 1'b0;
        bus.rd_en   = 1'b0;
        set_smp(0);
        tick();
        tick();

        // reset state
        chk("rst_count",    32'(bus.count),    32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        reset = 1'b0;
        tick();

        // trigger timing
        arm_pulse();
        for (int i = 0; i < 3; i++) tick();
        chk("armed_no_rec", 32'(bus.count), 32'd0);
        bus.trig = 1'b1; bus.nl = 4'h5; bus.speaker = 1'b0; bus.nloss = 1'b1;
        tick();
        bus.trig = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_smp(i);
            bus.stop = (i == 4);
            tick();
        end
        bus.stop = 1'b0;
        chk("trig_count", 32'(bus.count), 32'd5);
        chk("trig_done",  32'(bus.done),  32'd1);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("trig_rd0_valid", 32'(bus.rd_valid), 32'd1);
        chk("trig_rd0_data",  32'(bus.rd_data),  32'h000B);
        tick();
        chk("trig_rd_gap_valid", 32'(bus.rd_valid), 32'd0);
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("trig_rd_data", 32'(bus.rd_data), rec(i, i));
        end
        tick();
        bus.rd_en = 1'b0;
        chk("empty_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("empty_rd_hold",  32'(bus.rd_data),  rec(4, 4));
        chk("empty_count",    32'(bus.count),    32'd0);

        // full / overflow
        arm_pulse();
        bus.trig = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_smp(i);
            tick();
        end
        bus.trig = 1'b0;
        chk("full_count",   32'(bus.count),    32'd16);
        chk("full_flag",    32'(bus.full),     32'd1);
        chk("full_no_ovf",  32'(bus.overflow), 32'd0);
        chk("full_no_done", 32'(bus.done),     32'd0);
        bus.rd_en = 1'b1;
        tick();
        chk("capture_rd_ignored", 32'(bus.rd_valid), 32'd0);
        bus.rd_en = 1'b0;
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_done", 32'(bus.done),     32'd1);
        chk("ovf_count", 32'(bus.count),   32'd16);
        bus.rd_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            chk("drain_valid", 32'(bus.rd_valid), 32'd1);
            chk("drain_data",  32'(bus.rd_data),  rec(i, i));
        end
        tick();
        bus.rd_en = 1'b0;
        chk("drain_17th_valid", 32'(bus.rd_valid), 32'd0);

        // stop together with the write that fills the buffer
        arm_pulse();
        chk("rearm_clears_ovf", 32'(bus.overflow), 32'd0);
        bus.trig = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            set_smp(i);
            bus.stop = (i == DEPTH - 1);
            tick();
        end
        bus.stop = 1'b0;
        bus.trig = 1'b0;
        chk("stopfull_count", 32'(bus.count),    32'd16);
        chk("stopfull_ovf",   32'(bus.overflow), 32'd0);
        chk("stopfull_done",  32'(bus.done),     32'd1);

        // re-arm during readout
        arm_pulse();
        bus.trig = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_smp(i);
            bus.stop = (i == 9);
            tick();
        end
        bus.stop = 1'b0;
        bus.trig = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("rearm_rd2_data", 32'(bus.rd_data), rec(2, 2));
        chk("rearm_rd_count", 32'(bus.count),   32'd7);
        bus.arm = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.rd_en = 1'b0;
        chk("rearm_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rearm_count",    32'(bus.count),    32'd0);
        chk("rearm_done",     32'(bus.done),     32'd0);
        bus.trig = 1'b1;
        set_smp(9);
        tick();
        bus.trig = 1'b0;
        set_smp(10);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("rearm_new_count", 32'(bus.count), 32'd2);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        chk("rearm_new_rec0", 32'(bus.rd_data), rec(0, 9));

`ifdef CONC_TRACE_DEDUP_EN
        // dedup: 6 cycles of nl=3 then 2 of nl=7
        arm_pulse();
        bus.trig = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_smp((i < 6) ? 3 : 7);
            bus.stop = (i == 7);
            tick();
        end
        bus.stop = 1'b0;
        bus.trig = 1'b0;
        chk("dedup_count", 32'(bus.count), 32'd2);
        bus.rd_en = 1'b1;
        tick();
        chk("dedup_rec0", 32'(bus.rd_data), rec(0, 3));
        tick();
        bus.rd_en = 1'b0;
        chk("dedup_rec1", 32'(bus.rd_data), rec(6, 7));

        // dedup: stamp saturation over a long constant stretch
        arm_pulse();
        bus.trig = 1'b1;
        for (int i = 0; i < 301; i++) begin
            set_smp((i < 300) ? 3 : 7);
            bus.stop = (i == 300);
            tick();
        end
        bus.stop = 1'b0;
        bus.trig = 1'b0;
        chk("sat_count", 32'(bus.count), 32'd2);
        bus.rd_en = 1'b1;
        tick();
        tick();
        bus.rd_en = 1'b0;
        chk("sat_rec1", 32'(bus.rd_data), rec(255, 7));
`endif

        // reset mid-capture
        arm_pulse();
        bus.trig = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_smp(i + 1);
            tick();
        end
        bus.trig = 1'b0;
        chk("mid_count_pre", 32'(bus.count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count",    32'(bus.count),    32'd0);
        chk("mid_rst_done",     32'(bus.done),     32'd0);
        chk("mid_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("mid_rst_overflow", 32'(bus.overflow), 32'd0);
        tick();
        reset = 1'b0;
        // back in IDLE: a trigger without arm records nothing
        bus.trig = 1'b1;
        set_smp(6);
        tick();
        tick();
        bus.trig = 1'b0;
        chk("idle_trig_ignored", 32'(bus.count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/conc_trace_recorder.md
Name: conc_trace_recorder

Overview:
- Response-side counterpart of the concolic stimulus player: where the player reads opcodes from RAM and drives the b12 inputs (`__obs`, `k`, `start`), this block samples the b12 outputs (`nloss`, `nl`, `speaker`) every cycle.
- Each sample is written as a time-stamped record into an internal trace buffer.
- The buffer is drained through a one-cycle-latency read port by the bench or a checker.
- Sits beside the DUT instance in generated benches; capture starts on a trigger (normally `__obs`).

Parameters:
- DEPTH, 16, number of trace records (power of two, ≥2); localparam AW = clog2(DEPTH).
- STAMP_W, 8, width of the cycle stamp; localparam REC_W = STAMP_W + 6.

Ports:
- clock  in  1  sampling clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  single-cycle pulse: clear buffer, enter ARMED
- stop  in  1  single-cycle pulse: end capture
- trig  in  1  capture-start qualifier, level-sensitive in ARMED
- nloss  in  1  DUT output
- nl  in  4  DUT output
- speaker  in  1  DUT output
- rd_en  in  1  read request
- rd_valid  out  1  rd_data valid this cycle
- rd_data  out  REC_W  {stamp, speaker, nl[3:0], nloss}
- count  out  AW+1  records currently held
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a capture cycle was dropped because the buffer was full
- done  out  1  state == DONE

Behaviour:
- Reset: applied asynchronously.
  - State = IDLE; pointers, count, stamp = 0.
  - rd_valid = 0, rd_data = 0, overflow = 0, full = 0, done = 0.
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE:
  - arm → ARMED.
  - Reads allowed (buffer empty after reset).
- ARMED:
  - On the first edge with trig = 1, that edge's sample is written as record 0 with stamp 0; state → CAPTURE.
  - stop → DONE with no records.
  - arm re-clears the buffer and stays in ARMED.
- CAPTURE:
  - Each edge writes {stamp, sample} at wr_ptr; wr_ptr and count increment.
  - The stamp increments every CAPTURE edge and saturates at all-ones; it never wraps.
  - If full on an edge: no write, overflow ← 1, → DONE.
  - stop on an edge: that edge's sample is still written if not full, then → DONE.
  - stop together with the write that fills the buffer: write happens, → DONE, overflow stays 0.
  - arm is ignored.
- DONE:
  - No writes.
  - arm clears wr_ptr, rd_ptr, count, stamp and overflow → ARMED.
  - stop and trig are ignored.
- Read port (active in IDLE and DONE only):
  - rd_en with count > 0: next cycle rd_valid = 1 and rd_data = mem[rd_ptr]; rd_ptr increments, count decrements.
  - rd_en with count = 0, or in ARMED/CAPTURE: ignored; rd_valid = 0 next cycle; rd_data holds its last value.
  - Back-to-back rd_en gives one record per cycle.
- Pointers wrap modulo DEPTH.
- arm and rd_en in the same DONE cycle: arm wins; the read is dropped and rd_valid = 0.
- full is combinational from count.
- done, rd_valid and overflow are registered.

Optional Feature:
- Macro: CONC_TRACE_DEDUP_EN.
- Defined: in CAPTURE, a record is written only when the sample differs from the last written sample.
  - Record 0 is always written.
  - The stamp keeps counting every cycle, so records carry the absolute offset of each change.
  - overflow is set only when a changed sample finds the buffer full.
- Undefined: every CAPTURE cycle is written, as above.

Test Plan:
- Reset mid-capture: after 5 records, assert reset → count = 0, done = 0, rd_valid = 0, overflow = 0 immediately; state = IDLE.
- Trigger timing: arm; trig = 0 for 3 cycles, then trig = 1 with nl = 4'h5, speaker = 0, nloss = 1; stop after 4 more edges → count = 5; first read gives rd_data = {8'd0, 0, 4'h5, 1} one cycle after rd_en; last stamp = 4.
- Full/overflow, DEPTH = 16: capture without stop → full = 1 after 16 records; the next edge gives overflow = 1 and done = 1; draining 16 reads returns stamps 0..15 in order; a 17th rd_en gives rd_valid = 0.
- Simultaneous stop and final write: stop on the edge writing record 15 → count = 16, overflow = 0, done = 1.
- Re-arm during readout: read 3 of 10 records, then arm with rd_en high → no rd_valid, count = 0, state ARMED; the new capture starts at stamp 0.
- With CONC_TRACE_DEDUP_EN, STAMP_W = 8: hold nl = 4'h3 for 6 cycles, then 4'h7 for 2, then stop → count = 2, stamps 0 and 6.
- With CONC_TRACE_DEDUP_EN, stamp saturation: a 300-cycle constant capture ending in one change gives that record's stamp = 8'hFF.
